// File: rtl/compute_score_vec.sv
// rtl/compute_score_vec.sv - 5-stage anchor-pair chaining score pipeline (optional reject logic: COMPUTE_SCORE_REJECT_EN)
module compute_score_vec #(
  parameter int DW       = 32,
  parameter int TAGW     = 8,
  parameter int AVG_FRAC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   riX,
  input  logic [DW-1:0]   riY,
  input  logic [DW-1:0]   qiX,
  input  logic [DW-1:0]   qiY,
  input  logic [DW-1:0]   W,
  input  logic [DW-1:0]   W_avg,
  input  logic [DW-1:0]   max_dist,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   result,
  output logic            out_reject,
  output logic [TAGW-1:0] out_tag
);

  localparam int LW = $clog2(DW);
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // One global advance: the whole pipe moves or the whole pipe holds.
  logic w_adv;
  logic r5_valid;
  assign w_adv    = !r5_valid || out_ready;
  assign in_ready = w_adv;

  // ---------------- stage 1 ----------------
  logic            r1_valid;
  logic [DW-1:0]   r1_dr, r1_dq, r1_w, r1_wavg;
  logic [TAGW-1:0] r1_tag;
`ifdef COMPUTE_SCORE_REJECT_EN
  logic [DW-1:0]   r1_maxd;
`endif

  // Stage 1 register: anchor distances on reference and query axes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r1_dr    <= '0;
      r1_dq    <= '0;
      r1_w     <= '0;
      r1_wavg  <= '0;
      r1_tag   <= '0;
`ifdef COMPUTE_SCORE_REJECT_EN
      r1_maxd  <= '0;
`endif
    end else if (w_adv) begin
      r1_valid <= in_valid;
      r1_dr    <= abs_diff(riX, riY);
      r1_dq    <= abs_diff(qiX, qiY);
      r1_w     <= W;
      r1_wavg  <= W_avg;
      r1_tag   <= in_tag;
`ifdef COMPUTE_SCORE_REJECT_EN
      r1_maxd  <= max_dist;
`endif
    end
  end

  // ---------------- stage 2 ----------------
  logic [DW-1:0] w_dd, w_mn;
  logic          w_rej;
  assign w_dd = abs_diff(r1_dr, r1_dq);
  assign w_mn = (r1_dr < r1_dq) ? r1_dr : r1_dq;
`ifdef COMPUTE_SCORE_REJECT_EN
  assign w_rej = (r1_dr == '0) || (r1_dq == '0) || (r1_dr > r1_maxd) || (r1_dq > r1_maxd);
`else
  // Threshold input has no consumer when rejection is compiled out.
  logic w_unused_max_dist;
  assign w_unused_max_dist = ^max_dist;
  assign w_rej = 1'b0;
`endif

  logic            r2_valid, r2_rej;
  logic [DW-1:0]   r2_dd, r2_mn, r2_w, r2_wavg;
  logic [TAGW-1:0] r2_tag;

  // Stage 2 register: gap difference, shorter span and reject flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r2_valid <= 1'b0;
      r2_rej   <= 1'b0;
      r2_dd    <= '0;
      r2_mn    <= '0;
      r2_w     <= '0;
      r2_wavg  <= '0;
      r2_tag   <= '0;
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      r2_rej   <= w_rej;
      r2_dd    <= w_dd;
      r2_mn    <= w_mn;
      r2_w     <= r1_w;
      r2_wavg  <= r1_wavg;
      r2_tag   <= r1_tag;
    end
  end

  // ---------------- stage 3 ----------------
  logic [DW-1:0]   w_a;
  logic [2*DW-1:0] w_p;
  logic [LW-1:0]   w_l;
  assign w_a = (r2_mn < r2_w) ? r2_mn : r2_w;
  assign w_p = (2*DW)'(r2_dd) * (2*DW)'(r2_wavg);

  // Index of the highest set bit of dd; stays 0 when dd is 0.
  always_comb begin
    w_l = '0;
    for (int i = 0; i < DW; i++) begin
      if (r2_dd[i]) w_l = LW'(i);
    end
  end

  logic            r3_valid, r3_rej, r3_ddz;
  logic [DW-1:0]   r3_a;
  logic [2*DW-1:0] r3_p;
  logic [LW-1:0]   r3_l;
  logic [TAGW-1:0] r3_tag;

  // Stage 3 register: capped match term, full-width gap product, log2 of gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r3_valid <= 1'b0;
      r3_rej   <= 1'b0;
      r3_ddz   <= 1'b0;
      r3_a     <= '0;
      r3_p     <= '0;
      r3_l     <= '0;
      r3_tag   <= '0;
    end else if (w_adv) begin
      r3_valid <= r2_valid;
      r3_rej   <= r2_rej;
      r3_ddz   <= (r2_dd == '0);
      r3_a     <= w_a;
      r3_p     <= w_p;
      r3_l     <= w_l;
      r3_tag   <= r2_tag;
    end
  end

  // ---------------- stage 4 ----------------
  // The shifted product is below 2^(2*DW-AVG_FRAC), so the sum cannot wrap.
  logic [2*DW-1:0] w_bsum;
  logic [DW-1:0]   w_b;
  assign w_bsum = (r3_p >> AVG_FRAC) + (2*DW)'(r3_l >> 1);
  assign w_b    = r3_ddz ? '0 :
                  (w_bsum > (2*DW)'(SMAX)) ? SMAX : w_bsum[DW-1:0];

  logic            r4_valid, r4_rej;
  logic [DW-1:0]   r4_a, r4_b;
  logic [TAGW-1:0] r4_tag;

  // Stage 4 register: saturated gap penalty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r4_valid <= 1'b0;
      r4_rej   <= 1'b0;
      r4_a     <= '0;
      r4_b     <= '0;
      r4_tag   <= '0;
    end else if (w_adv) begin
      r4_valid <= r3_valid;
      r4_rej   <= r3_rej;
      r4_a     <= r3_a;
      r4_b     <= w_b;
      r4_tag   <= r3_tag;
    end
  end

  // ---------------- stage 5 ----------------
  // A is unsigned up to 2^DW-1, so the difference needs one extra bit before clamping.
  logic signed [DW:0] w_diff;
  logic [DW-1:0]      w_res;
  assign w_diff = $signed({1'b0, r4_a}) - $signed({1'b0, r4_b});
  assign w_res  = (w_diff > $signed({1'b0, SMAX})) ? SMAX :
                  (w_diff < $signed({1'b1, SMIN})) ? SMIN : w_diff[DW-1:0];

  logic            r5_rej;
  logic [DW-1:0]   r5_result;
  logic [TAGW-1:0] r5_tag;

  // Stage 5 register: signed saturated score presented on the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r5_valid  <= 1'b0;
      r5_rej    <= 1'b0;
      r5_result <= '0;
      r5_tag    <= '0;
    end else if (w_adv) begin
      r5_valid  <= r4_valid;
      r5_rej    <= r4_rej;
      r5_result <= w_res;
      r5_tag    <= r4_tag;
    end
  end

  assign out_valid  = r5_valid;
  assign result     = r5_result;
  assign out_reject = r5_rej;
  assign out_tag    = r5_tag;

endmodule

// File: tb/tb_compute_score_vec.sv
// tb/tb_compute_score_vec.sv - self-checking bench for compute_score_vec (honours COMPUTE_SCORE_REJECT_EN)
module tb_compute_score_vec;
  localparam int DW   = 32;
  localparam int TAGW = 8;
`ifdef COMPUTE_SCORE_REJECT_EN
  localparam bit REJ_EN = 1'b1;
`else
  localparam bit REJ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, in_valid, in_ready, out_valid, out_ready, out_reject;
  logic [DW-1:0]   riX, riY, qiX, qiY, W, W_avg, max_dist, result;
  logic [TAGW-1:0] in_tag, out_tag;

  compute_score_vec dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .riX(riX), .riY(riY), .qiX(qiX), .qiY(qiY), .W(W), .W_avg(W_avg),
    .max_dist(max_dist), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_reject(out_reject), .out_tag(out_tag)
  );

  typedef struct {
    logic [31:0] rix, riy, qix, qiy, w, wavg, maxd, res;
    logic        rej;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        rej;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   n_stall = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard: compare every output transfer against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got tag 0x%0h expected no output", out_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {32'd0, result}, {32'd0, e.res});
        check("reject", {63'd0, out_reject}, {63'd0, e.rej});
        check("tag", {56'd0, out_tag}, {56'd0, e.tag});
        n_out++;
      end
    end
  end

  // Present one transaction (called #1 after a rising edge), wait for acceptance, queue its expectation.
  task automatic drive(input vec_t v, input logic [7:0] tag);
    int cnt;
    exp_t e;
    in_valid = 1'b1;
    riX = v.rix; riY = v.riy; qiX = v.qix; qiY = v.qiy;
    W = v.w; W_avg = v.wavg; max_dist = v.maxd; in_tag = tag;
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 for tag 0x%0h", tag);
    end else begin
      e.res = v.res;
      e.rej = v.rej & REJ_EN;
      e.tag = tag;
      sb.push_back(e);
      n_stall += cnt;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int base;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    riX = '0; riY = '0; qiX = '0; qiY = '0; W = '0; W_avg = '0; max_dist = '0; in_tag = '0;

    //          rix           riy  qix    qiy           w             wavg   maxd          res           rej
    vecs[0] = '{32'd100,      32'd60, 32'd90,   32'd60,      32'd15,       32'd64,  32'd5000,     32'd4,        1'b0};
    vecs[1] = '{32'd30,       32'd10, 32'd5,    32'd25,      32'd50,       32'd64,  32'd5000,     32'd20,       1'b0};
    vecs[2] = '{32'd7,        32'd7,  32'd10,   32'd3,       32'd10,       32'd64,  32'd5000,     32'hFFFFFFF8, 1'b1};
    vecs[3] = '{32'd1000,     32'd0,  32'd6000, 32'd0,       32'd2000,     32'd1,   32'd5000,     32'd916,      1'b1};
    vecs[4] = '{32'h7FFFFFFF, 32'd0,  32'd5,    32'd5,       32'd100,      32'hFF,  32'd5000,     32'h80000001, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 32'd0,  32'd0,    32'hFFFFFFFF,32'hFFFFFFFF, 32'd0,   32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0};
    vecs[6] = '{32'd5,        32'd0,  32'd0,    32'd3,       32'd0,        32'd128, 32'd5000,     32'hFFFFFFFC, 1'b0};
    vecs[7] = '{32'd4,        32'd0,  32'd3,    32'd0,       32'd3,        32'd64,  32'd5000,     32'd2,        1'b0};
    vecs[8] = '{32'd5000,     32'd0,  32'd4990, 32'd0,       32'd100,      32'd0,   32'd5000,     32'd99,       1'b0};
    vecs[9] = '{32'd5001,     32'd0,  32'd4991, 32'd0,       32'd100,      32'd0,   32'd5000,     32'd99,       1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_out_tag", {56'd0, out_tag}, 64'd0);
    reset = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single-transaction latency, counted in edges including the accepting one
    drive(vecs[0], 8'h01);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", 64'(cnt), 64'd5);
    drain("drain_latency");

    // Table of vectors, back to back
    for (int i = 0; i < 10; i++) drive(vecs[i], 8'(8'h10 + i));
    drain("drain_table");

    // 16 back-to-back with no stalls
    base = n_out;
    n_stall = 0;
    for (int i = 0; i < 16; i++) drive(vecs[1], 8'(8'h20 + i));
    check("b2b_no_stall", 64'(n_stall), 64'd0);
    drain("drain_b2b");
    check("b2b_count", 64'(n_out - base), 64'd16);

    // Backpressure: 5 accepts fill the pipe, then everything holds
    base = n_out;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(vecs[i], 8'(8'h40 + i));
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    check("bp_head_tag", {56'd0, out_tag}, 64'h40);
    fork
      drive(vecs[5], 8'h45);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_tag", {56'd0, out_tag}, 64'h40);
        check("bp_hold_result", {32'd0, result}, {32'd0, vecs[0].res});
        check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
      end
    join
    drive(vecs[6], 8'h46);
    drive(vecs[7], 8'h47);
    drain("drain_bp");
    check("bp_count", 64'(n_out - base), 64'd8);

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) drive(vecs[2 + i], 8'(8'h60 + i));
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_result", {32'd0, result}, 64'd0);
    check("midrst_reject", {63'd0, out_reject}, 64'd0);
    check("midrst_tag", {56'd0, out_tag}, 64'd0);
    reset = 1'b0;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check("midrst_no_stale", 64'(cnt), 64'd0);

    // Pipe still works after the mid-flight reset
    drive(vecs[9], 8'h70);
    drain("drain_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
